// File: rtl/bcd_run_controller.sv
// Start/stop/zero controller for a chain of cascaded BCD counter digits with a prescaled tick.
// Optional lap latch enabled by defining BCD_RUN_CTRL_LAP_EN.
module bcd_run_controller #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 10
) (
  input  logic                  clk_i,
  input  logic                  clear_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  zero_i,
  input  logic [4*DIGITS-1:0]   target_i,
`ifdef BCD_RUN_CTRL_LAP_EN
  input  logic                  lap_i,
  output logic [4*DIGITS-1:0]   lap_value_o,
`endif
  output logic [4*DIGITS-1:0]   count_o,
  output logic [DIGITS-1:0]     digit_en_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  wrap_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PresMax = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic [DIGITS-1:0]     digit_en_q, digit_en_d;
  logic                  wrap_q, wrap_d;
  logic                  tick;
  logic                  go;

  always_comb begin
    logic                carry;
    logic [3:0]          dig;
    logic [4*DIGITS-1:0] inc;
    logic                hit;

    state_d    = state_q;
    presc_d    = presc_q;
    count_d    = count_q;
    digit_en_d = '0;
    inc        = count_q;
    go         = start_i && !stop_i;
    tick       = (state_q == StRun) && (presc_q == PresMax) && !zero_i;

    // Decimal ripple: each digit is enabled only while every lower digit rolls over.
    carry = tick;
    for (int i = 0; i < DIGITS; i++) begin
      dig                = count_q[4*i +: 4];
      digit_en_d[i]      = carry;
      inc[4*i +: 4]      = carry ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      carry              = carry && (dig == 4'd9);
    end
    wrap_d = carry;
    hit    = (target_i != '0) && (inc == target_i);

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StRun;
          presc_d = '0;
        end
      end
      StRun: begin
        count_d = inc;
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (stop_i) begin
          state_d = StPause;
          if (!tick) presc_d = presc_q;
        end
        if (tick && hit) begin
          state_d = StDone;
          presc_d = '0;
        end
      end
      StPause: begin
        if (go) state_d = StRun;
      end
      StDone: begin
        if (go) begin
          state_d = StRun;
          count_d = '0;
          presc_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (zero_i) begin
      state_d = StIdle;
      count_d = '0;
      presc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      count_q    <= '0;
      digit_en_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      digit_en_q <= digit_en_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef BCD_RUN_CTRL_LAP_EN
  logic [4*DIGITS-1:0] lap_q, lap_d;

  always_comb begin
    lap_d = lap_q;
    if (zero_i) begin
      lap_d = '0;
    end else if (lap_i && (state_q == StRun || state_q == StPause)) begin
      lap_d = count_d;
    end
  end

  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) lap_q <= '0;
    else           lap_q <= lap_d;
  end

  assign lap_value_o = lap_q;
`endif

  assign count_o    = count_q;
  assign digit_en_o = digit_en_q;
  assign running_o  = (state_q == StRun);
  assign done_o     = (state_q == StDone);
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_bcd_run_controller.sv
// Bench for bcd_run_controller: two DUTs (PRESCALE 3 and 1) on shared inputs checked against
// an integer-arithmetic model; lap checks only when BCD_RUN_CTRL_LAP_EN is defined.
module tb_bcd_run_controller;

  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, zero = 1'b0;
  logic [15:0] target = '0;
  logic [15:0] count1, count3;
  logic [3:0]  den1, den3;
  logic        run1, run3, done1, done3, wrap1, wrap3;
`ifdef BCD_RUN_CTRL_LAP_EN
  logic        lap = 1'b0;
  logic [15:0] lapv1, lapv3;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_run_controller #(.DIGITS(4), .PRESCALE(3)) dut3 (
    .clk_i(clk), .clear_ni(clear_n), .start_i(start), .stop_i(stop), .zero_i(zero),
    .target_i(target),
`ifdef BCD_RUN_CTRL_LAP_EN
    .lap_i(lap), .lap_value_o(lapv3),
`endif
    .count_o(count3), .digit_en_o(den3), .running_o(run3), .done_o(done3), .wrap_o(wrap3)
  );

  bcd_run_controller #(.DIGITS(4), .PRESCALE(1)) dut1 (
    .clk_i(clk), .clear_ni(clear_n), .start_i(start), .stop_i(stop), .zero_i(zero),
    .target_i(target),
`ifdef BCD_RUN_CTRL_LAP_EN
    .lap_i(lap), .lap_value_o(lapv1),
`endif
    .count_o(count1), .digit_en_o(den1), .running_o(run1), .done_o(done1), .wrap_o(wrap1)
  );

  typedef struct {
    int st;
    int pre;
    int cnt;
    int den;
    bit wrp;
  } mdl_t;

  mdl_t m1, m3;

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    int x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) return -1;
      r = r * 10 + int'(b[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m.st = MIdle; m.pre = 0; m.cnt = 0; m.den = 0; m.wrp = 1'b0;
    return m;
  endfunction

  // Stopwatch behaviour expressed as integer arithmetic on the decimal count.
  function automatic mdl_t mstep(input mdl_t m, input int ps, input bit s, input bit p,
                                 input bit z, input int tgt);
    mdl_t n = m;
    bit   go = s && !p;
    n.den = 0;
    n.wrp = 1'b0;
    if (z) begin
      n.st = MIdle; n.cnt = 0; n.pre = 0;
      return n;
    end
    case (m.st)
      MIdle:  if (go) begin n.st = MRun; n.pre = 0; end
      MPause: if (go) n.st = MRun;
      MDone:  if (go) begin n.st = MRun; n.cnt = 0; n.pre = 0; end
      default: begin
        bit tk = (m.pre == ps - 1);
        n.pre = tk ? 0 : m.pre + 1;
        if (p) begin
          n.st = MPause;
          if (!tk) n.pre = m.pre;
        end
        if (tk) begin
          int k = 0;
          int v = m.cnt;
          while (k < 4 && v % 10 == 9) begin k++; v = v / 10; end
          n.den = (k == 4) ? 15 : (1 << (k + 1)) - 1;
          n.wrp = (m.cnt == 9999);
          n.cnt = (m.cnt + 1) % 10000;
          if (tgt > 0 && n.cnt == tgt) begin n.st = MDone; n.pre = 0; end
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [22:0] pk(input mdl_t m);
    return {int2bcd(m.cnt), 4'(m.den), m.st == MRun, m.st == MDone, m.wrp};
  endfunction

  task automatic cmp(input string nm, input logic [22:0] act, input logic [22:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit s, input bit p, input bit z);
    start = s; stop = p; zero = z;
    @(posedge clk);
    m1 = mstep(m1, 1, s, p, z, bcd2int(target));
    m3 = mstep(m3, 3, s, p, z, bcd2int(target));
    #1;
    cmp("model_p1", {count1, den1, run1, done1, wrap1}, pk(m1));
    cmp("model_p3", {count3, den3, run3, done3, wrap3}, pk(m3));
    start = 1'b0; stop = 1'b0; zero = 1'b0;
  endtask

  task automatic do_clear();
    #3 clear_n = 1'b0;
    #1;
    m1 = mreset();
    m3 = mreset();
    cmp("clear_p1", {count1, den1, run1, done1, wrap1}, 23'd0);
    cmp("clear_p3", {count3, den3, run3, done3, wrap3}, 23'd0);
    #1 clear_n = 1'b1;
  endtask

  typedef struct packed {
    bit        s;
    bit        p;
    bit        z;
    logic [15:0] cnt;
    logic [3:0]  den;
    bit        run;
    bit        dn;
    bit        wr;
  } vec_t;

  vec_t vec[11];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m1 = mreset();
    m3 = mreset();
    // PRESCALE=3 sequence: latency, pause with held prescaler, resume, zero.
    vec[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 4'h1, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 4'h0, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 4'h0, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 1'b0, 16'h0002, 4'h1, 1'b1, 1'b0, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0};

    #12 clear_n = 1'b1;
    #1;
    cmp("reset_p3", {count3, den3, run3, done3, wrap3}, 23'd0);
    cmp("reset_p1", {count1, den1, run1, done1, wrap1}, 23'd0);

    for (int i = 0; i < 11; i++) begin
      step(vec[i].s, vec[i].p, vec[i].z);
      cmp($sformatf("vec%0d", i), {count3, den3, run3, done3, wrap3},
          {vec[i].cnt, vec[i].den, vec[i].run, vec[i].dn, vec[i].wr});
    end

    // Carry into the tens digit.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (count3 == 16'h0010) break;
    end
    cmp("carry_0010", {7'd0, count3, den3}, {7'd0, 16'h0010, 4'b0011});

    // All-9s rollover on the PRESCALE=1 instance.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10010; i++) begin
      if (count1 == 16'h9999) break;
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    cmp("wrap_edge", {4'd0, count1, den1, wrap1, run1}, {4'd0, 16'h0000, 4'hF, 1'b1, 1'b1});
    step(1'b0, 1'b0, 1'b0);
    cmp("wrap_pulse", {21'd0, wrap1, run1}, {21'd0, 1'b0, 1'b1});

    // Terminal count 0015 and restart from DONE.
    step(1'b0, 1'b0, 1'b1);
    target = 16'h0015;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done1) break;
    end
    cmp("done_hit", {5'd0, count1, run1, done1}, {5'd0, 16'h0015, 1'b0, 1'b1});
    step(1'b0, 1'b0, 1'b0);
    cmp("done_hold", {5'd0, count1, run1, done1}, {5'd0, 16'h0015, 1'b0, 1'b1});
    step(1'b1, 1'b0, 1'b0);
    cmp("done_restart", {5'd0, count1, run1, done1}, {5'd0, 16'h0000, 1'b1, 1'b0});
    step(1'b0, 1'b0, 1'b1);
    target = 16'h0000;

    // Clear asserted mid-run at 0042.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (count1 == 16'h0042) break;
      step(1'b0, 1'b0, 1'b0);
    end
    cmp("at_0042", {7'd0, count1, 4'd0}, {7'd0, 16'h0042, 4'd0});
    do_clear();
    step(1'b0, 1'b0, 1'b0);

    // Pause with prescaler at 1 of 3, then resume.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    cmp("pause_enter", {22'd0, run3}, 23'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cmp("resume_1", {7'd0, count3}, {7'd0, 16'h0000});
    step(1'b0, 1'b0, 1'b0);
    cmp("resume_2", {7'd0, count3}, {7'd0, 16'h0001});
    step(1'b1, 1'b1, 1'b0);
    cmp("start_stop", {21'd0, run3, done3}, 23'd0);

`ifdef BCD_RUN_CTRL_LAP_EN
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    lap = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    lap = 1'b0;
    begin
      logic [15:0] e1, e3;
      e1 = int2bcd(m1.cnt);
      e3 = int2bcd(m3.cnt);
      cmp("lap_p1", {7'd0, lapv1}, {7'd0, e1});
      cmp("lap_p3", {7'd0, lapv3}, {7'd0, e3});
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
      cmp("lap_hold_p1", {7'd0, lapv1}, {7'd0, e1});
    end
    step(1'b0, 1'b0, 1'b1);
    cmp("lap_zero", {7'd0, lapv1 | lapv3}, 23'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       target = 16'h0000;
          1:       target = int2bcd($urandom_range(1, 40));
          2:       target = 16'h00A3;
          default: target = int2bcd($urandom_range(0, 9999));
        endcase
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) do_clear();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
